hello_world_rx: RTL and testbench
=================================

# hello_world_rx

Receive-side counterpart of the `hello_world` message sender. It deserializes an 8N1 UART line into bytes and checks the byte stream against the fixed 13-character message "Hello, World!". When the full message arrives in order, it emits a single-cycle `match` pulse. It sits at the far end of the serial link and serves as a loopback checker and board-level link test.

## Interface

Parameters:

- `CLOCK_RATE`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: serial bit rate.
- `CLOCKS_PER_BIT`, default CLOCK_RATE / BAUD_RATE: clock cycles per bit (integer division). Legal values are 4 or more.

Ports:

- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-low.
- `rx`, input, 1: serial line, asynchronous to `clk`, idles high.
- `data`, output, 8: last received byte. It holds its value until the next good byte.
- `valid`, output, 1: one-cycle pulse when `data` holds a newly received good byte.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.
- `match`, output, 1: one-cycle pulse when "Hello, World!" has been received in full.
- `busy`, output, 1: high while a frame is in progress (state is not IDLE).

## Operation

**Synchronizer**
- `rx` passes through two flops. Both reset to 1.
- All sampling uses the synchronized value `rx_s`.

**Receiver FSM.** States are IDLE, START, DATA and STOP. A bit counter `cnt` runs from 0 to CLOCKS_PER_BIT-1, and `bitidx` runs from 0 to 7.
- IDLE: when `rx_s`=0, go to START with `cnt`=0.
- START: at `cnt` = CLOCKS_PER_BIT/2 - 1 (start-bit midpoint), sample `rx_s`.
  - If 0: go to DATA with `cnt`=0 and `bitidx`=0.
  - If 1: treat as a glitch and go to IDLE. No output pulses.
- DATA: at `cnt` = CLOCKS_PER_BIT-1, sample `rx_s` into shift register bit `bitidx` (LSB first).
  - After `bitidx`=7, go to STOP with `cnt`=0.
- STOP: at `cnt` = CLOCKS_PER_BIT-1, sample `rx_s` and return to IDLE in the same step.
  - If 1: load `data` and pulse `valid` on the next cycle.
  - If 0: pulse `frame_err` on the next cycle. `data` is unchanged and `valid` is not pulsed.
- The return to IDLE at the stop-bit midpoint allows back-to-back frames without losing a start edge.

**Matcher.** Index `idx` is 4 bits, range 0..12, and is compared against the ROM "Hello, World!".
- On `valid` with `data` equal to `MSG[idx]`:
  - If `idx`=12: set `idx` to 0 and pulse `match` on the following cycle.
  - Otherwise: `idx` becomes `idx`+1.
- On `valid` with a mismatch: `idx` becomes 1 if `data`="H" (0x48), else 0. This is correct because "H" occurs only at position 0.
- On `frame_err`: `idx` becomes 0.

**Reset** (`rst`=0 at a clock edge) takes priority over everything, including mid-frame and mid-message:
- FSM goes to IDLE; `cnt`, `bitidx` and `idx` go to 0.
- `data` = 0x00; `valid`, `frame_err`, `match` and `busy` = 0.
- Synchronizer flops = 1.

## Timing

- Synchronizer latency is 2 cycles.
- `busy` rises 3 cycles after a falling edge on `rx`. It stays high through START, DATA and STOP, and falls in the cycle `valid` or `frame_err` pulses (or on glitch rejection).
- `valid` or `frame_err` asserts 2 + CLOCKS_PER_BIT/2 + 9·CLOCKS_PER_BIT + 1 cycles after the `rx` start edge. The bench tolerance is ±1 cycle.
- `match` asserts exactly 1 cycle after the `valid` that carries "!" (0x21).
- `valid`, `frame_err` and `match` are each exactly one cycle wide. `valid` and `frame_err` are never high together.
- With continuous back-to-back frames at the nominal rate, every byte is received and no cycles of bit time are lost between frames.
- A low pulse on `rx` shorter than CLOCKS_PER_BIT/2 - 2 cycles is rejected as a glitch.

## Test plan

Use CLOCK_RATE=1_000_000 and BAUD_RATE=100_000, giving CLOCKS_PER_BIT=10.

1. Send a single frame 0x55 with a good stop bit → exactly one `valid`, `data`=0x55, `frame_err`=0, `match`=0. Check `valid` timing against the Timing formula.
2. Send "Hello, World!" as 13 back-to-back frames → 13 `valid` pulses with the correct bytes, and exactly one `match` one cycle after the 13th `valid`.
3. Send "HeHello, World!" → 15 `valid` pulses and one `match` after the final "!". Then send "Hello, World?" → no `match`.
4. Send 0xA5 with the stop bit driven 0 → one `frame_err`, no `valid`, `data` keeps its prior value. Then send "Hello, World!" → `match` asserts.
5. Drive `rx` low for 3 cycles, then high → `busy` pulses briefly, with no `valid`, `frame_err` or `match`.
6. Assert reset (`rst`=0) during DATA of the 7th message byte, then release it and send the full message → all outputs are 0 during reset, the first full message yields `match`, and there are no spurious pulses.

Source files
------------

// File: rtl/hello_world_rx.sv
// 8N1 UART receiver that checks the incoming byte stream for "Hello, World!".
// It emits one-cycle valid / frame_err / match pulses.
module hello_world_rx #(
  parameter int CLOCK_RATE     = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int CLOCKS_PER_BIT = CLOCK_RATE / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       match,
  output logic       busy
);

  localparam int CW = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST    = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic          rx_meta_q, rx_s_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bitidx_q;
  logic [7:0]    shift_q, data_q;
  logic          valid_q, frame_err_q, match_q, match_d;
  logic [3:0]    idx_q, idx_d;

  function automatic logic [7:0] msg_byte(input logic [3:0] i);
    case (i)
      4'd0:    msg_byte = 8'h48;
      4'd1:    msg_byte = 8'h65;
      4'd2:    msg_byte = 8'h6C;
      4'd3:    msg_byte = 8'h6C;
      4'd4:    msg_byte = 8'h6F;
      4'd5:    msg_byte = 8'h2C;
      4'd6:    msg_byte = 8'h20;
      4'd7:    msg_byte = 8'h57;
      4'd8:    msg_byte = 8'h6F;
      4'd9:    msg_byte = 8'h72;
      4'd10:   msg_byte = 8'h6C;
      4'd11:   msg_byte = 8'h64;
      4'd12:   msg_byte = 8'h21;
      default: msg_byte = 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receiver FSM; the stop bit is sampled at its midpoint so the next start edge is never missed.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bitidx_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            if (!rx_s_q) begin
              state_q  <= DATA;
              cnt_q    <= '0;
              bitidx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (cnt_q == LAST) begin
            shift_q[bitidx_q] <= rx_s_q;
            cnt_q             <= '0;
            if (bitidx_q == 3'd7) state_q <= STOP;
            else                  bitidx_q <= bitidx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (cnt_q == LAST) begin
            state_q <= IDLE;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // 'H' appears only at position 0, so a mismatch falls back to index 1 or 0.
  always_comb begin
    idx_d   = idx_q;
    match_d = 1'b0;
    if (frame_err_q) begin
      idx_d = 4'd0;
    end else if (valid_q) begin
      if (data_q == msg_byte(idx_q)) begin
        if (idx_q == 4'd12) begin
          idx_d   = 4'd0;
          match_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end else if (data_q == 8'h48) begin
        idx_d = 4'd1;
      end else begin
        idx_d = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q   <= '0;
      match_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      match_q <= match_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign match     = match_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_hello_world_rx.sv
// Bench for hello_world_rx: serial frames are generated bit by bit and the
// expected byte / error / match events come from a string-level message model.
module tb_hello_world_rx;

  localparam int C = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, match, busy;

  hello_world_rx #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .data(data), .valid(valid),
    .frame_err(frame_err), .match(match), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  typedef struct {int start; bit good; bit m;} frame_t;

  string      msg = "Hello, World!";
  logic [7:0] exp_q[$];
  frame_t     fr_q[$];
  logic [7:0] hist[$];
  logic [7:0] held_exp = 8'h00;
  int         match_due = -10;
  int         n_match_exp = 0;
  int         n_match_seen = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ends_with_msg();
    if (hist.size() < 13) return 1'b0;
    for (int i = 0; i < 13; i++)
      if (hist[hist.size() - 13 + i] != msg[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: a match is due whenever the good bytes received since the
  // last reset / framing error end with the full message.
  task automatic model_push(input logic [7:0] b, input bit good, input int start);
    bit m;
    if (good) begin
      exp_q.push_back(b);
      hist.push_back(b);
      m = ends_with_msg();
      if (m) hist.delete();
      n_match_exp += int'(m);
      fr_q.push_back('{start, 1'b1, m});
    end else begin
      hist.delete();
      fr_q.push_back('{start, 1'b0, 1'b0});
    end
  endtask

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic send_byte(input logic [7:0] b, input bit stop, input int gap);
    model_push(b, stop, cyc);
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop;
    repeat (C) @(negedge clk);
    rx = 1'b1;
    repeat (gap * C) @(negedge clk);
  endtask

  task automatic send_msg(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1, 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    frame_t f;
    logic [7:0] e;
    int lat;
    bit exp_m;
    if (!rst) held_exp = 8'h00;
    if (valid || frame_err) check("valid_ferr_excl", 32'(valid & frame_err), 0);
    if (valid) begin
      if (fr_q.size() == 0) check("spurious_valid", 1, 0);
      else begin
        f = fr_q.pop_front();
        check("frame_kind_valid", 1, 32'(f.good));
        if (f.good) begin
          e = exp_q.pop_front();
          check("data", 32'(data), 32'(e));
          held_exp = e;
          if (f.m) match_due = cyc + 1;
        end
        lat = cyc - f.start;
        check("valid_latency_in_97_99", 32'(lat >= 97 && lat <= 99), 1);
      end
    end
    if (frame_err) begin
      if (fr_q.size() == 0) check("spurious_frame_err", 1, 0);
      else begin
        f = fr_q.pop_front();
        check("frame_kind_ferr", 0, 32'(f.good));
        if (f.good) void'(exp_q.pop_front());
        check("data_held_on_ferr", 32'(data), 32'(held_exp));
        lat = cyc - f.start;
        check("ferr_latency_in_97_99", 32'(lat >= 97 && lat <= 99), 1);
      end
    end
    exp_m = (match_due == cyc);
    if (match) n_match_seen++;
    if (match || exp_m) check("match", 32'(match), 32'(exp_m));
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [7:0] b;
    bit         stop;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_outputs", {data, valid, frame_err, match, busy}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // 1: single frame
    send_byte(8'h55, 1'b1, 2);
    check("t1_data", 32'(data), 32'h55);
    check("t1_no_match", n_match_seen, 0);

    // 2: the message back to back
    send_msg("Hello, World!");
    repeat (3) @(negedge clk);
    check("t2_match_count", n_match_seen, 1);

    // 3: restart inside a prefix, then a near miss
    send_msg("HeHello, World!");
    send_msg("Hello, World?");
    repeat (3) @(negedge clk);
    check("t3_match_count", n_match_seen, 2);

    // 4: framing error keeps data, then a full message
    send_byte(8'hA5, 1'b0, 2);
    check("t4_data_held", 32'(data), 32'h3F);
    send_msg("Hello, World!");
    repeat (3) @(negedge clk);
    check("t4_match_count", n_match_seen, 3);

    // 5: short glitch
    repeat (20) @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    check("t5_busy_high", 32'(busy), 1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_busy_low", 32'(busy), 0);
    repeat (10) @(negedge clk);

    // 6: reset during DATA of the 7th message byte
    send_msg("Hello,");
    rx = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = ((8'h20 >> i) & 8'h01) != 0;
      repeat (C) @(negedge clk);
    end
    check("t6_busy_before_reset", 32'(busy), 1);
    rst = 1'b0;
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_reset_outputs", {data, valid, frame_err, match, busy}, 0);
      if (i == 1) rx = 1'b1;
    end
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_msg("Hello, World!");
    repeat (3) @(negedge clk);
    check("t6_match_count", n_match_seen, 4);

    // random bytes, random stop bits and gaps, message characters mixed in
    for (int n = 0; n < 30; n++) begin
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) b = msg[$urandom_range(0, 12)];
      stop = ($urandom_range(0, 7) != 0);
      send_byte(b, stop, stop ? $urandom_range(0, 2) : $urandom_range(1, 3));
      if (n == 14) send_msg("Hello, World!");
    end

    for (int t = 0; t < 400 && fr_q.size() != 0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("frames_drained", fr_q.size(), 0);
    check("match_total", n_match_seen, n_match_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
